// File: rtl/ysyx_22050710_ifu_if.sv
// Fetch-unit bundle: PC control, instruction-memory request/response and decode handshake.
// o_inst_misalign exists only when YSYX_22050710_IFU_MISALIGN_CHK_EN is defined.
interface ysyx_22050710_ifu_if #(
  parameter int unsigned PC_WD   = 64,
  parameter int unsigned INST_WD = 32
);
  logic [PC_WD-1:0]   i_pc;
  logic               o_pc_load;
  logic               i_flush;
  logic               o_imem_req_valid;
  logic               i_imem_req_ready;
  logic [PC_WD-1:0]   o_imem_addr;
  logic               i_imem_rsp_valid;
  logic [INST_WD-1:0] i_imem_rsp_data;
  logic               o_inst_valid;
  logic               i_inst_ready;
  logic [INST_WD-1:0] o_inst;
  logic [PC_WD-1:0]   o_inst_pc;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
  logic               o_inst_misalign;
`endif

  modport master (
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
    output o_inst_misalign,
`endif
    input  i_pc,
    input  i_flush,
    input  i_imem_req_ready,
    input  i_imem_rsp_valid,
    input  i_imem_rsp_data,
    input  i_inst_ready,
    output o_pc_load,
    output o_imem_req_valid,
    output o_imem_addr,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc
  );

  modport slave (
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
    input  o_inst_misalign,
`endif
    output i_pc,
    output i_flush,
    output i_imem_req_ready,
    output i_imem_rsp_valid,
    output i_imem_rsp_data,
    output i_inst_ready,
    input  o_pc_load,
    input  o_imem_req_valid,
    input  o_imem_addr,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc
  );
endinterface

// File: rtl/ysyx_22050710_ifu.sv
// Instruction fetch unit: one outstanding imem request, single-entry instruction buffer, flush drop.
// Optional misaligned-PC trap path enabled by YSYX_22050710_IFU_MISALIGN_CHK_EN.
module ysyx_22050710_ifu #(
  parameter int unsigned PC_WD   = 64,
  parameter int unsigned INST_WD = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  ysyx_22050710_ifu_if.master    bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e             state_q, state_d;
  logic [PC_WD-1:0]   addr_q, addr_d;
  logic [PC_WD-1:0]   inst_pc_q, inst_pc_d;
  logic [INST_WD-1:0] inst_q, inst_d;
  logic               drop_q, drop_d;
  logic               inst_valid_q, inst_valid_d;
  logic               pc_load;
  logic               req_valid;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
  logic               misalign_q, misalign_d;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    inst_pc_d    = inst_pc_q;
    inst_d       = inst_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    pc_load      = 1'b0;
    req_valid    = 1'b0;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
    misalign_d   = misalign_q;
`endif

    unique case (state_q)
      StIdle: begin
        addr_d  = bus.i_pc;
        state_d = StReq;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
        // Misaligned PC never reaches memory; decode sees a flagged null instruction.
        if (bus.i_pc[1:0] != 2'b00) begin
          state_d      = StHold;
          inst_d       = '0;
          inst_pc_d    = bus.i_pc;
          inst_valid_d = 1'b1;
          misalign_d   = 1'b1;
        end
`endif
      end

      StReq: begin
        // A raised request stays up through a flush; the flush only marks its response stale.
        req_valid = 1'b1;
        if (bus.i_flush) begin
          pc_load = 1'b1;
          drop_d  = 1'b1;
        end
        if (bus.i_imem_req_ready) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (bus.i_flush) begin
          pc_load = 1'b1;
          drop_d  = 1'b1;
          if (bus.i_imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end
        end else if (bus.i_imem_rsp_valid) begin
          if (drop_q) begin
            // Stale response: refetch straight from the already-redirected PC.
            drop_d  = 1'b0;
            addr_d  = bus.i_pc;
            state_d = StReq;
          end else begin
            inst_d       = bus.i_imem_rsp_data;
            inst_pc_d    = addr_q;
            inst_valid_d = 1'b1;
            state_d      = StHold;
          end
        end
      end

      StHold: begin
        if (bus.i_flush || bus.i_inst_ready) begin
          pc_load      = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = StIdle;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
          misalign_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // Handshake outputs are masked during reset so a mid-transaction reset is silent at once.
  assign bus.o_pc_load        = pc_load & ~i_rst;
  assign bus.o_imem_req_valid = req_valid & ~i_rst;
  assign bus.o_imem_addr      = addr_q;
  assign bus.o_inst_valid     = inst_valid_q & ~i_rst;
  assign bus.o_inst           = inst_q;
  assign bus.o_inst_pc        = inst_pc_q;
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
  assign bus.o_inst_misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// Bench for ysyx_22050710_ifu: directed scenarios plus a randomized run checked against an
// architectural model (delivered instruction stream follows PC+4 and flush targets).
module tb_ysyx_22050710_ifu;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic [63:0] tgt;
  logic        ld_s;
  logic        fl_s;
  int          checks;
  int          errors;
  int          ld_cnt;
  int          bad_cnt;

  ysyx_22050710_ifu_if #(.PC_WD(64), .INST_WD(32)) bus ();

  ysyx_22050710_ifu #(.PC_WD(64), .INST_WD(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ 32'h1357_9BDF;
  endfunction

  // Called at a negedge: records PC-register activity and advances one clock.
  task automatic adv();
    ld_s = bus.o_pc_load;
    fl_s = bus.i_flush;
    if (ld_s) ld_cnt++;
    if (bus.o_inst_valid && bus.o_inst == 32'hDEADBEEF) bad_cnt++;
    @(posedge clk);
    #1;
    if (ld_s) pc = fl_s ? tgt : pc + 64'd4;
    bus.i_pc = pc;
  endtask

  task automatic rst_dut(input logic [63:0] start_pc);
    rst = 1'b1;
    pc  = start_pc;
    tgt = '0;
    bus.i_pc             = pc;
    bus.i_flush          = 1'b0;
    bus.i_imem_req_ready = 1'b0;
    bus.i_imem_rsp_valid = 1'b0;
    bus.i_imem_rsp_data  = '0;
    bus.i_inst_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ld_cnt  = 0;
    bad_cnt = 0;
  endtask

  // Stops at the negedge where a request is visible (no clock advance on success).
  task automatic wait_req(output logic got, output logic [63:0] a);
    got = 1'b0;
    a   = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.o_imem_req_valid) begin
        got = 1'b1;
        a   = bus.o_imem_addr;
        break;
      end
      adv();
    end
  endtask

  task automatic wait_inst(output logic got);
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.o_inst_valid) begin
        got = 1'b1;
        break;
      end
      adv();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_flush          = 1'b1;
    bus.i_imem_req_ready = 1'b1;
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'h1234_5678;
    bus.i_inst_ready     = 1'b1;
    bus.i_pc             = 64'h8000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid: got %0b want 0", bus.o_imem_req_valid);
    end
    checks++;
    if (bus.o_inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_inst_valid: got %0b want 0", bus.o_inst_valid);
    end
    checks++;
    if (bus.o_pc_load !== 1'b0) begin
      errors++; $display("FAIL reset_pc_load: got %0b want 0", bus.o_pc_load);
    end
    checks++;
    if (bus.o_inst !== 32'h0 || bus.o_inst_pc !== 64'h0 || bus.o_imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: inst %h pc %h addr %h want all 0",
               bus.o_inst, bus.o_inst_pc, bus.o_imem_addr);
    end
  endtask

  task automatic test_basic();
    logic got;
    logic [63:0] a;
    rst_dut(64'h8000_0000);
    bus.i_imem_req_ready = 1'b1;
    bus.i_inst_ready     = 1'b1;
    wait_req(got, a);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL basic_req_seen: got 0 want 1"); end
    checks++;
    if (a !== 64'h8000_0000) begin
      errors++; $display("FAIL basic_addr: got %h want 80000000", a);
    end
    adv();
    repeat (2) begin @(negedge clk); adv(); end
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'h0000_0013;
    @(negedge clk);
    adv();
    bus.i_imem_rsp_valid = 1'b0;
    bus.i_imem_rsp_data  = '0;
    wait_inst(got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL basic_inst_seen: got 0 want 1"); end
    checks++;
    if (bus.o_inst !== 32'h0000_0013 || bus.o_inst_pc !== 64'h8000_0000) begin
      errors++;
      $display("FAIL basic_inst: got %h@%h want 00000013@80000000", bus.o_inst, bus.o_inst_pc);
    end
    adv();
    repeat (4) begin @(negedge clk); adv(); end
    checks++;
    if (ld_cnt != 1) begin errors++; $display("FAIL basic_pc_load_count: got %0d want 1", ld_cnt); end
  endtask

  task automatic test_req_stall();
    logic got;
    logic [63:0] a;
    rst_dut(64'h8000_0040);
    wait_req(got, a);
    checks++;
    if (got !== 1'b1 || a !== 64'h8000_0040) begin
      errors++; $display("FAIL stall_first_req: got %0b/%h want 1/80000040", got, a);
    end
    for (int k = 0; k < 5; k++) begin
      adv();
      @(negedge clk);
      checks++;
      if (bus.o_imem_req_valid !== 1'b1 || bus.o_imem_addr !== a) begin
        errors++;
        $display("FAIL stall_hold cyc %0d: valid %0b addr %h want 1/%h",
                 k, bus.o_imem_req_valid, bus.o_imem_addr, a);
      end
    end
    bus.i_imem_req_ready = 1'b1;
    adv();
    bus.i_imem_req_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_imem_req_valid !== 1'b0 || bus.o_inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait: req %0b inst %0b want 0/0",
               bus.o_imem_req_valid, bus.o_inst_valid);
    end
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'hCAFE_0001;
    adv();
    bus.i_imem_rsp_valid = 1'b0;
    wait_inst(got);
    checks++;
    if (got !== 1'b1 || bus.o_inst !== 32'hCAFE_0001 || bus.o_inst_pc !== a) begin
      errors++;
      $display("FAIL stall_inst: got %0b %h@%h want 1 cafe0001@%h",
               got, bus.o_inst, bus.o_inst_pc, a);
    end
  endtask

  task automatic test_flush_wait();
    logic got;
    logic [63:0] a;
    rst_dut(64'h8000_0000);
    bus.i_imem_req_ready = 1'b1;
    wait_req(got, a);
    adv();
    bus.i_imem_req_ready = 1'b0;
    bus.i_flush = 1'b1;
    tgt = 64'h8000_0100;
    @(negedge clk);
    checks++;
    if (bus.o_pc_load !== 1'b1) begin
      errors++; $display("FAIL flushw_pc_load: got %0b want 1", bus.o_pc_load);
    end
    adv();
    bus.i_flush = 1'b0;
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    adv();
    bus.i_imem_rsp_valid = 1'b0;
    bus.i_imem_rsp_data  = '0;
    wait_req(got, a);
    checks++;
    if (got !== 1'b1 || a !== 64'h8000_0100) begin
      errors++; $display("FAIL flushw_next_addr: got %0b/%h want 1/80000100", got, a);
    end
    bus.i_imem_req_ready = 1'b1;
    adv();
    bus.i_imem_req_ready = 1'b0;
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'h0010_0093;
    @(negedge clk);
    adv();
    bus.i_imem_rsp_valid = 1'b0;
    wait_inst(got);
    checks++;
    if (got !== 1'b1 || bus.o_inst !== 32'h0010_0093 || bus.o_inst_pc !== 64'h8000_0100) begin
      errors++;
      $display("FAIL flushw_inst: got %0b %h@%h want 1 00100093@80000100",
               got, bus.o_inst, bus.o_inst_pc);
    end
    bus.i_inst_ready = 1'b1;
    adv();
    bus.i_inst_ready = 1'b0;
    checks++;
    if (bad_cnt != 0) begin
      errors++; $display("FAIL flushw_dropped: deadbeef seen %0d times want 0", bad_cnt);
    end
  endtask

  task automatic test_flush_hold();
    logic got;
    logic [63:0] a;
    rst_dut(64'h8000_0000);
    bus.i_imem_req_ready = 1'b1;
    wait_req(got, a);
    adv();
    bus.i_imem_req_ready = 1'b0;
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'h0000_0013;
    @(negedge clk);
    adv();
    bus.i_imem_rsp_valid = 1'b0;
    wait_inst(got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL flushh_hold: got 0 want 1"); end
    ld_cnt = 0;
    bus.i_inst_ready = 1'b1;
    bus.i_flush      = 1'b1;
    tgt = 64'h8000_0200;
    #1;
    checks++;
    if (bus.o_pc_load !== 1'b1) begin
      errors++; $display("FAIL flushh_pc_load: got %0b want 1", bus.o_pc_load);
    end
    adv();
    bus.i_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_inst_valid !== 1'b0) begin
      errors++; $display("FAIL flushh_discard: inst_valid %0b want 0", bus.o_inst_valid);
    end
    adv();
    wait_req(got, a);
    checks++;
    if (got !== 1'b1 || a !== 64'h8000_0200) begin
      errors++; $display("FAIL flushh_target: got %0b/%h want 1/80000200", got, a);
    end
    checks++;
    if (ld_cnt != 1) begin errors++; $display("FAIL flushh_load_count: got %0d want 1", ld_cnt); end
    bus.i_inst_ready = 1'b0;
  endtask

  task automatic test_reset_wait();
    logic got;
    logic [63:0] a;
    rst_dut(64'h8000_0000);
    bus.i_imem_req_ready = 1'b1;
    wait_req(got, a);
    adv();
    bus.i_imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_imem_req_valid !== 1'b0 || bus.o_inst_valid !== 1'b0 || bus.o_pc_load !== 1'b0) begin
      errors++;
      $display("FAIL rstw_outputs: req %0b inst %0b ld %0b want 0/0/0",
               bus.o_imem_req_valid, bus.o_inst_valid, bus.o_pc_load);
    end
    adv();
    rst = 1'b0;
    pc = 64'h8000_0000;
    bus.i_pc = pc;
    bus.i_imem_rsp_valid = 1'b1;
    bus.i_imem_rsp_data  = 32'hBADC_0DE0;
    @(negedge clk);
    checks++;
    if (bus.o_inst_valid !== 1'b0 || bus.o_inst !== 32'h0 || bus.o_inst_pc !== 64'h0 ||
        bus.o_imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL rstw_cleared: valid %0b inst %h pc %h addr %h want 0",
               bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, bus.o_imem_addr);
    end
    adv();
    bus.i_imem_rsp_valid = 1'b0;
    wait_req(got, a);
    checks++;
    if (got !== 1'b1 || a !== 64'h8000_0000) begin
      errors++; $display("FAIL rstw_refetch: got %0b/%h want 1/80000000", got, a);
    end
    bus.i_imem_req_ready = 1'b1;
    adv();
    bus.i_imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.o_inst_valid !== 1'b0) begin
        errors++; $display("FAIL rstw_stray cyc %0d: inst_valid 1 want 0", k);
      end
      adv();
    end
  endtask

`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
  task automatic test_misalign();
    int reqs;
    rst_dut(64'h8000_0002);
    bus.i_imem_req_ready = 1'b1;
    reqs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.o_imem_req_valid) reqs++;
      adv();
    end
    @(negedge clk);
    checks++;
    if (reqs != 0) begin errors++; $display("FAIL misalign_no_req: got %0d reqs want 0", reqs); end
    checks++;
    if (bus.o_inst_valid !== 1'b1 || bus.o_inst_misalign !== 1'b1 || bus.o_inst !== 32'h0) begin
      errors++;
      $display("FAIL misalign_hold: valid %0b flag %0b inst %h want 1/1/0",
               bus.o_inst_valid, bus.o_inst_misalign, bus.o_inst);
    end
    bus.i_inst_ready = 1'b1;
    adv();
    bus.i_inst_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_inst_misalign !== 1'b0) begin
      errors++; $display("FAIL misalign_clear: flag %0b want 0", bus.o_inst_misalign);
    end
    adv();
  endtask
`endif

  task automatic test_random();
    logic [63:0] exp_pc;
    logic [63:0] out_addr;
    logic [63:0] prev_addr;
    logic        outstanding;
    logic        prev_stall;
    logic        prev_ld;
    logic        prev_fl;
    logic        acc;
    int          lat;
    int          delivered;
    rst_dut(64'h8000_0000);
    exp_pc = 64'h8000_0000;
    out_addr = '0;
    prev_addr = '0;
    outstanding = 1'b0;
    prev_stall = 1'b0;
    prev_ld = 1'b0;
    prev_fl = 1'b0;
    lat = 0;
    delivered = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.i_imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.i_inst_ready     = ($urandom_range(0, 2) != 0);
      if (outstanding && lat == 0) begin
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_data  = mem_word(out_addr);
      end else begin
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = $urandom;
      end
      if (!prev_fl && (bus.o_imem_req_valid || bus.o_inst_valid || outstanding) &&
          $urandom_range(0, 11) == 0) begin
        bus.i_flush = 1'b1;
        tgt = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
      end else begin
        bus.i_flush = 1'b0;
      end
      @(negedge clk);
      acc = bus.o_inst_valid && bus.i_inst_ready && !bus.i_flush;
      if (acc) begin
        checks++;
        if (bus.o_pc_load !== 1'b1) begin
          errors++; $display("FAIL rnd_accept_load cyc %0d: got %0b want 1", n, bus.o_pc_load);
        end
        checks++;
        if (bus.o_inst_pc !== exp_pc) begin
          errors++; $display("FAIL rnd_inst_pc cyc %0d: got %h want %h", n, bus.o_inst_pc, exp_pc);
        end
        checks++;
        if (bus.o_inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rnd_inst cyc %0d: got %h want %h", n, bus.o_inst, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end else if (bus.i_flush) begin
        checks++;
        if (bus.o_pc_load !== 1'b1) begin
          errors++; $display("FAIL rnd_flush_load cyc %0d: got %0b want 1", n, bus.o_pc_load);
        end
        exp_pc = tgt;
      end else begin
        checks++;
        if (bus.o_pc_load !== 1'b0) begin
          errors++; $display("FAIL rnd_spurious_load cyc %0d: got %0b want 0", n, bus.o_pc_load);
        end
      end
      if (outstanding) begin
        checks++;
        if (bus.o_imem_req_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_one_outstanding cyc %0d: req_valid 1 want 0", n);
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.o_imem_req_valid !== 1'b1 || bus.o_imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL rnd_req_stable cyc %0d: valid %0b addr %h want 1/%h",
                   n, bus.o_imem_req_valid, bus.o_imem_addr, prev_addr);
        end
      end
      if (prev_ld) begin
        checks++;
        if (bus.o_pc_load === 1'b1) begin
          errors++; $display("FAIL rnd_double_load cyc %0d: got 1 want 0", n);
        end
      end
      if (bus.i_imem_rsp_valid) outstanding = 1'b0;
      else if (outstanding) lat--;
      if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
        outstanding = 1'b1;
        out_addr = bus.o_imem_addr;
        lat = $urandom_range(0, 3);
      end
      prev_stall = bus.o_imem_req_valid && !bus.i_imem_req_ready;
      prev_addr  = bus.o_imem_addr;
      prev_ld    = bus.o_pc_load;
      prev_fl    = bus.i_flush;
      adv();
    end
    bus.i_flush = 1'b0;
    bus.i_imem_rsp_valid = 1'b0;
    checks++;
    if (delivered < 50) begin
      errors++; $display("FAIL rnd_progress: delivered %0d want >= 50", delivered);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ld_cnt  = 0;
    bad_cnt = 0;
    rst = 1'b1;
    pc  = 64'h8000_0000;
    tgt = '0;
    test_reset();
    test_basic();
    test_req_stall();
    test_flush_wait();
    test_flush_hold();
    test_reset_wait();
`ifdef YSYX_22050710_IFU_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
